// File: rtl/pcie_c2h_pkg.sv
// Shared FSM encoding, default constants and slot address helper for the C2H descriptor scheduler.
`default_nettype none

package pcie_c2h_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [27:0] DEF_SLOT_BYTES   = 28'h1000;
  localparam logic [63:0] DEF_BASE_ADDR    = 64'h0000_0001_0000_0000;
  localparam int          DEF_MAX_INFLIGHT = 2;

  // Full 64-bit product so large rings never truncate the host address.
  function automatic logic [63:0] slot_addr(input logic [63:0] base,
                                            input logic [63:0] idx,
                                            input logic [27:0] nbytes);
    return base + idx * {36'd0, nbytes};
  endfunction

endpackage

`default_nettype wire

// File: rtl/updown_cnt.sv
// Up/down counter saturating at 0 and MAX; rej flags a step that was refused at a bound.
`default_nettype none

module updown_cnt #(
  parameter int W       = 4,
  parameter int MAX     = 15,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         rej
);

  localparam logic [W-1:0] CMAX = W'(MAX);
  localparam logic [W-1:0] CRST = W'(RST_VAL);

  logic up_only;
  logic dn_only;

  assign up_only = inc && !dec;
  assign dn_only = dec && !inc;
  assign rej     = (up_only && (cnt == CMAX)) || (dn_only && (cnt == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= CRST;
    end else if (up_only && (cnt != CMAX)) begin
      cnt <= cnt + W'(1);
    end else if (dn_only && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcie_c2h_dsc_sched.sv
// Issues one XDMA C2H bypass descriptor per free host ring slot, bounded by in-flight and host credits.
`default_nettype none

module pcie_c2h_dsc_sched
  import pcie_c2h_pkg::*;
#(
  parameter int          NR_SLOTS     = 8,
  parameter logic [27:0] SLOT_BYTES   = DEF_SLOT_BYTES,
  parameter logic [63:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int          MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                        user_clk_250,
  input  logic                        user_reset_250,
  input  logic                        enable,
  input  logic                        dsc_byp_ready,
  output logic                        dsc_byp_load,
  output logic [63:0]                 dsc_byp_dst_addr,
  output logic [63:0]                 dsc_byp_src_addr,
  output logic [27:0]                 dsc_byp_len,
  output logic [15:0]                 dsc_byp_ctl,
  input  logic                        c2h_tvalid,
  input  logic                        c2h_tready,
  input  logic                        c2h_tlast,
  input  logic                        credit_return,
  output logic [$clog2(NR_SLOTS)-1:0] slot_idx,
  output logic [3:0]                  inflight,
  output logic [$clog2(NR_SLOTS):0]   credits,
  output logic                        pkt_done,
  output logic [1:0]                  err
);

  localparam int         SW      = $clog2(NR_SLOTS);
  localparam logic [3:0] MAX_INF = 4'(MAX_INFLIGHT);

  state_t        state;
  logic          issue_hs;
  logic          cpl;
  logic          inf_rej;
  logic          crd_rej;
  logic [SW-1:0] slot_nxt;

  assign issue_hs = (state == ISSUE) && dsc_byp_load && dsc_byp_ready;
  assign cpl      = c2h_tvalid && c2h_tready && c2h_tlast;
  assign slot_nxt = slot_idx + SW'(1);

  assign dsc_byp_src_addr = 64'd0;
  assign dsc_byp_len      = SLOT_BYTES;
  assign dsc_byp_ctl      = 16'd0;

  updown_cnt #(
    .W       (4),
    .MAX     (15),
    .RST_VAL (0)
  ) u_inflight (
    .clk (user_clk_250),
    .rst (user_reset_250),
    .inc (issue_hs),
    .dec (cpl),
    .cnt (inflight),
    .rej (inf_rej)
  );

  updown_cnt #(
    .W       (SW + 1),
    .MAX     (NR_SLOTS),
    .RST_VAL (NR_SLOTS)
  ) u_credits (
    .clk (user_clk_250),
    .rst (user_reset_250),
    .inc (credit_return),
    .dec (issue_hs),
    .cnt (credits),
    .rej (crd_rej)
  );

  always_ff @(posedge user_clk_250) begin
    if (user_reset_250) begin
      state            <= IDLE;
      dsc_byp_load     <= 1'b0;
      slot_idx         <= '0;
      dsc_byp_dst_addr <= BASE_ADDR;
      pkt_done         <= 1'b0;
      err              <= 2'b00;
    end else begin
      // A stray tlast is not a finished slot, so it raises err[0] but no pkt_done.
      pkt_done <= cpl && !inf_rej;
      err      <= err | {crd_rej, inf_rej};
      case (state)
        IDLE: begin
          if (enable && (credits != '0) && (inflight < MAX_INF)) begin
            state        <= ISSUE;
            dsc_byp_load <= 1'b1;
          end else if (!enable && (inflight != '0)) begin
            state <= DRAIN;
          end
        end
        ISSUE: begin
          // Once offered, the descriptor stays up until accepted, regardless of enable.
          if (dsc_byp_ready) begin
            state            <= IDLE;
            dsc_byp_load     <= 1'b0;
            slot_idx         <= slot_nxt;
            dsc_byp_dst_addr <= slot_addr(BASE_ADDR, 64'(slot_nxt), SLOT_BYTES);
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          dsc_byp_load <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pcie_c2h_dsc_sched.sv
// Directed self-checking bench for pcie_c2h_dsc_sched with hand-computed expectations.
`default_nettype none

module tb_pcie_c2h_dsc_sched;

  localparam logic [63:0] BASE = 64'h0000_0001_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dsc_byp_ready;
  logic        dsc_byp_load;
  logic [63:0] dsc_byp_dst_addr;
  logic [63:0] dsc_byp_src_addr;
  logic [27:0] dsc_byp_len;
  logic [15:0] dsc_byp_ctl;
  logic        c2h_tvalid;
  logic        c2h_tready;
  logic        c2h_tlast;
  logic        credit_return;
  logic [2:0]  slot_idx;
  logic [3:0]  inflight;
  logic [3:0]  credits;
  logic        pkt_done;
  logic [1:0]  err;

  int nvec = 0;
  int nerr = 0;

  pcie_c2h_dsc_sched dut (
    .user_clk_250     (clk),
    .user_reset_250   (rst),
    .enable           (enable),
    .dsc_byp_ready    (dsc_byp_ready),
    .dsc_byp_load     (dsc_byp_load),
    .dsc_byp_dst_addr (dsc_byp_dst_addr),
    .dsc_byp_src_addr (dsc_byp_src_addr),
    .dsc_byp_len      (dsc_byp_len),
    .dsc_byp_ctl      (dsc_byp_ctl),
    .c2h_tvalid       (c2h_tvalid),
    .c2h_tready       (c2h_tready),
    .c2h_tlast        (c2h_tlast),
    .credit_return    (credit_return),
    .slot_idx         (slot_idx),
    .inflight         (inflight),
    .credits          (credits),
    .pkt_done         (pkt_done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tlast(input logic v);
    c2h_tvalid = v;
    c2h_tready = v;
    c2h_tlast  = v;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    enable        = 1'b0;
    dsc_byp_ready = 1'b0;
    credit_return = 1'b0;
    set_tlast(1'b0);
    tick();
    tick();
  endtask

  task automatic wait_load(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (dsc_byp_load) begin
        ok = 1'b1;
        break;
      end
      if (i < budget) tick();
    end
  endtask

  // Runs with ready high, answering every handshake with a tlast on the next cycle.
  task automatic run_issues(input int cycles, output int n);
    bit hs_prev;
    hs_prev = 1'b0;
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      set_tlast(hs_prev);
      hs_prev = dsc_byp_load && dsc_byp_ready;
      if (hs_prev) n++;
      tick();
    end
    set_tlast(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit held;
    int n;

    // Reset values
    do_reset();
    check("rst_load", dsc_byp_load, 0);
    check("rst_slot", slot_idx, 0);
    check("rst_inflight", inflight, 0);
    check("rst_credits", credits, 8);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_err", err, 0);
    check("rst_dst", dsc_byp_dst_addr, BASE);
    check("const_src", dsc_byp_src_addr, 0);
    check("const_len", dsc_byp_len, 28'h1000);
    check("const_ctl", dsc_byp_ctl, 0);

    // Back-to-back issue up to the in-flight limit
    rst = 1'b0; enable = 1'b1; dsc_byp_ready = 1'b1;
    wait_load(2, ok);
    check("first_load_within_2", ok, 1);
    check("first_dst", dsc_byp_dst_addr, BASE);
    tick();
    check("after_hs1_load", dsc_byp_load, 0);
    check("after_hs1_inflight", inflight, 1);
    check("after_hs1_dst", dsc_byp_dst_addr, BASE + 64'h1000);
    tick();
    check("second_load", dsc_byp_load, 1);
    tick();
    check("after_hs2_inflight", inflight, 2);
    check("after_hs2_credits", credits, 6);
    held = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dsc_byp_load) held = 1'b1;
    end
    check("stall_at_max_inflight", held, 0);
    check("stall_inflight", inflight, 2);

    // Reset in the middle of ISSUE with ready high
    do_reset();
    rst = 1'b0; enable = 1'b1;
    wait_load(3, ok);
    check("mid_issue_load", ok, 1);
    rst = 1'b1; dsc_byp_ready = 1'b1;
    tick();
    check("rst_mid_issue_load", dsc_byp_load, 0);
    check("rst_mid_issue_inflight", inflight, 0);
    check("rst_mid_issue_credits", credits, 8);
    check("rst_mid_issue_slot", slot_idx, 0);

    // Ring wrap over 9 issues with a credit back after each tlast
    do_reset();
    rst = 1'b0; enable = 1'b1; dsc_byp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_load(4, ok);
      check($sformatf("wrap_load_%0d", k), ok, 1);
      check($sformatf("wrap_slot_%0d", k), slot_idx, 64'(k % 8));
      check($sformatf("wrap_dst_%0d", k), dsc_byp_dst_addr, BASE + 64'(k % 8) * 64'h1000);
      tick();
      set_tlast(1'b1); credit_return = 1'b1;
      tick();
      set_tlast(1'b0); credit_return = 1'b0;
    end
    check("wrap_credits", credits, 8);
    check("wrap_inflight", inflight, 0);

    // Ready held low while enable falls; then drain
    do_reset();
    rst = 1'b0; enable = 1'b1;
    wait_load(3, ok);
    check("hold_load_seen", ok, 1);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) enable = 1'b0;
      if (!dsc_byp_load || dsc_byp_dst_addr !== BASE) held = 1'b0;
      tick();
    end
    check("hold_stable_5", held, 1);
    check("hold_still_load", dsc_byp_load, 1);
    dsc_byp_ready = 1'b1;
    tick();
    check("hold_hs_load", dsc_byp_load, 0);
    check("hold_hs_inflight", inflight, 1);
    held = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dsc_byp_load) held = 1'b1;
    end
    check("drain_no_load", held, 0);
    check("drain_slot", slot_idx, 1);
    set_tlast(1'b1);
    tick();
    set_tlast(1'b0);
    check("drain_cpl_inflight", inflight, 0);
    check("drain_cpl_pkt_done", pkt_done, 1);
    tick();
    check("drain_pkt_done_clear", pkt_done, 0);

    // Credit exhaustion: exactly 8 issues, then one more per returned credit
    do_reset();
    rst = 1'b0; enable = 1'b1; dsc_byp_ready = 1'b1;
    run_issues(60, n);
    check("exhaust_issues", 64'(n), 8);
    check("exhaust_credits", credits, 0);
    check("exhaust_inflight", inflight, 0);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("one_credit", credits, 1);
    run_issues(20, n);
    check("one_more_issue", 64'(n), 1);
    check("one_more_credits", credits, 0);

    // Issue, completion and credit return in the same cycle
    do_reset();
    rst = 1'b0; enable = 1'b1; dsc_byp_ready = 1'b1;
    wait_load(3, ok);
    tick();
    check("sim_pre_inflight", inflight, 1);
    check("sim_pre_credits", credits, 7);
    tick();
    check("sim_load", dsc_byp_load, 1);
    set_tlast(1'b1); credit_return = 1'b1;
    tick();
    set_tlast(1'b0); credit_return = 1'b0;
    check("sim_inflight", inflight, 1);
    check("sim_credits", credits, 7);
    check("sim_pkt_done", pkt_done, 1);
    check("sim_slot", slot_idx, 2);
    enable = 1'b0;
    tick();
    check("sim_pkt_done_once", pkt_done, 0);
    check("sim_err", err, 0);

    // Stray tlast and excess credit return
    do_reset();
    rst = 1'b0;
    set_tlast(1'b1);
    tick();
    set_tlast(1'b0);
    check("stray_err0", err, 2'b01);
    check("stray_inflight", inflight, 0);
    check("stray_pkt_done", pkt_done, 0);
    repeat (4) tick();
    check("stray_err0_sticky", err, 2'b01);
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    check("extra_credit_err1", err, 2'b11);
    check("extra_credit_credits", credits, 8);
    do_reset();
    check("err_cleared_by_reset", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
